song_reader: RTL and testbench
==============================

# song_reader

Note sequencer for the music player: walks the 32-note score of the selected song, presents each note and its duration to the note player, and advances when that note finishes. It is the producer side of the song-done path. Its `duration` output and `co` wrap pulse drive the song-done detector. A duration of 0 or a `co` pulse both mean "song over" downstream.

## Interface
Parameters:
- `NOTE_W`, 6: note code width (0 = rest).
- `DUR_W`, 6: duration width (0 = end-of-song marker).
- `ADDR_W`, 5: note index width; 32 notes per song.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `play` in 1: level; 1 = run, 0 = pause/stop.
- `song` in 2: song select, one of 4 scores.
- `note_done` in 1: one-cycle pulse from note player; current note finished.
- `note` out NOTE_W: current note code, registered.
- `duration` out DUR_W: current note duration, registered.
- `new_note` out 1: one-cycle pulse; `note`/`duration` were just updated.
- `co` out 1: one-cycle pulse when note index 31 completes (wrap).

## Operation
- Score ROM: 128 words × (NOTE_W+DUR_W), addressed {song, index}. Word layout: note in upper bits, duration in lower bits. Synchronous read, 1-cycle latency.
- FSM states:
  - IDLE
    - Outputs `note`=0, `duration`=0.
    - `play`=1 → FETCH.
  - FETCH
    - ROM address driven from {song_q, index}.
    - Always → LOAD.
  - LOAD
    - Register ROM data into `note`/`duration`.
    - Fetched duration ≠ 0 → NEW.
    - Fetched duration = 0 → END.
  - NEW
    - `new_note`=1 for this cycle only.
    - Always → WAIT.
  - WAIT
    - `note_done`=1 and `play`=1 and index<31 → index+1, go to FETCH.
    - `note_done`=1 and `play`=1 and index=31 → `co`=1 for one cycle, index→0, go to END.
    - `note_done` while `play`=0 is ignored (pause). The note player is expected to stall too.
  - END
    - `duration` forced to 0, `note` to 0.
    - `play`=0 → IDLE.
- `song_q` is the registered `song`.
  - Any cycle with `song` ≠ `song_q`: index→0, `song_q`←`song`, outputs cleared, state→IDLE. This overrides every other transition, including a simultaneous `note_done`. No `co` is generated.
- Index is ADDR_W bits and wraps 31→0 only through the `co` path.

## Timing
- Reset (`reset_n`=0 at a `clk` edge):
  - state=IDLE, index=0, `song_q`=`song`.
  - `note`=0, `duration`=0, `new_note`=0, `co`=0.
  - Reset mid-song aborts the song with no `co`.
- Start latency: `play` high in IDLE at edge N → FETCH at N+1, LOAD at N+2. `note`/`duration` are valid and `new_note`=1 in the cycle after edge N+2; `new_note` deasserts after edge N+3.
- Note-to-note latency: `note_done` sampled at edge M → next `new_note` cycle starts after edge M+2, with outputs updated at edge M+2.
- `co` is registered: high in the cycle after the edge that samples the final `note_done`, coincident with entry to END. `duration` reads 0 in that same cycle.
- `new_note` and `co` are never high simultaneously.
- `note_done` arriving in FETCH/LOAD/NEW is ignored (no queueing).

## Structure
- Shared package holds:
  - FSM state encoding: IDLE, FETCH, LOAD, NEW, WAIT, END.
  - NOTE_W, DUR_W, ADDR_W.
  - Song count of 4.
- One sub-module, `song_rom`: synchronous-read ROM, 7-bit address, 12-bit data, initialised from the score file.
- Top holds the FSM, the index counter, `song_q` and the output registers.

## Test plan
- Reset then `play`=1, song 0, ROM word 0 = note 5 / duration 12 → `new_note` pulse 3 cycles after `play` sampled; `note`=5, `duration`=12.
- Song 1 with 32 nonzero entries, `note_done` pulsed 2 cycles after each `new_note` → 32 `new_note` pulses, then exactly one `co` pulse. After `co`: `duration`=0, state END, index=0.
- Song 2 with entry 3 duration=0 → 3 `new_note` pulses, then `duration`=0 and `note`=0. No `co` and no 4th `new_note`.
- `play` dropped in WAIT while `note_done` pulses → index unchanged and no `new_note`. `play` re-raised then `note_done` → next note issued 2 cycles later.
- `song` changed 1→3 in the same cycle as `note_done` at index 31 → no `co`, outputs 0, IDLE. Next start plays song 3 from entry 0.
- `reset_n`=0 for one edge mid-song at index 17 → all outputs 0 next cycle. Restart begins at index 0.

Source files
------------

// File: rtl/song_reader_pkg.sv
// song_reader_pkg
// Shared definitions for the note sequencer.
//   - Widths of note code, duration and note index, and the number of songs.
//   - Sequencer FSM state encoding.
//   - score_word(): the score contents, one 12-bit word per {song, index}.
//     The note code is in the upper bits and the duration in the lower bits.
//     Each song's entry is generated from a small per-song rule, so the ROM
//     synthesises to plain logic and needs no external file.
package song_reader_pkg;

   localparam int NOTE_WIDTH = 6;
   localparam int DUR_WIDTH  = 6;
   localparam int ADDR_WIDTH = 5;
   localparam int SONG_COUNT = 4;
   localparam int SONG_W     = $clog2(SONG_COUNT);
   localparam int ROM_AW     = SONG_W + ADDR_WIDTH;
   localparam int ROM_DW     = NOTE_WIDTH + DUR_WIDTH;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_NEW   = 3'd3,
      ST_WAIT  = 3'd4,
      ST_END   = 3'd5
   } state_t;

   // Score contents. Song 2 carries an end-of-song marker (duration 0) at
   // entry 3; the other songs use nonzero durations throughout.
   function automatic logic [ROM_DW-1:0] score_word(input logic [ROM_AW-1:0] addr);
      logic [SONG_W-1:0]     sel_s;
      logic [NOTE_WIDTH-1:0] idx_s;
      logic [NOTE_WIDTH-1:0] note_s;
      logic [DUR_WIDTH-1:0]  dur_s;
      sel_s = addr[ROM_AW-1:ADDR_WIDTH];
      idx_s = {1'b0, addr[ADDR_WIDTH-1:0]};
      case (sel_s)
         2'd0: begin
            note_s = idx_s + 6'd5;
            dur_s  = 6'd12 + {4'd0, idx_s[1:0]};
         end
         2'd1: begin
            note_s = idx_s + 6'd32;
            dur_s  = idx_s + 6'd1;
         end
         2'd2: begin
            note_s = idx_s + 6'd10;
            if (idx_s == 6'd3) begin
               dur_s = 6'd0;
            end else begin
               dur_s = idx_s + 6'd4;
            end
         end
         2'd3: begin
            note_s = 6'd63 - idx_s;
            dur_s  = 6'd40 - idx_s;
         end
         default: begin
            note_s = 6'd0;
            dur_s  = 6'd0;
         end
      endcase
      return {note_s, dur_s};
   endfunction

endpackage

// File: rtl/song_rom.sv
// song_rom
// Synchronous-read score ROM, 128 words x 12 bits, one-cycle read latency.
// Ports:
//   clk   in   system clock
//   addr  in   {song, note index}
//   data  out  {note code, duration}, registered
module song_rom
   import song_reader_pkg::*;
(
   input  logic              clk,
   input  logic [ROM_AW-1:0] addr,
   output logic [ROM_DW-1:0] data
);

   logic [ROM_DW-1:0] data_r;

   // Registered ROM read: address sampled every edge, word valid next cycle
   always_ff @(posedge clk) begin
      data_r <= score_word(addr);
   end

   assign data = data_r;

endmodule

// File: rtl/song_reader.sv
// song_reader
// Note sequencer: walks the 32-note score of the selected song, presents each
// note and its duration, and advances when the note player reports the note
// finished. A zero duration or a co pulse tells the downstream song-done
// detector that the song is over.
// Ports:
//   clk        in   system clock
//   reset_n    in   synchronous active-low reset
//   play       in   level, 1 = run, 0 = pause/stop
//   song       in   song select (4 scores)
//   note_done  in   one-cycle pulse, current note finished
//   note       out  current note code, registered
//   duration   out  current note duration, registered (0 = song over)
//   new_note   out  one-cycle pulse, note/duration just updated
//   co         out  one-cycle pulse when the last note (index 31) completes
module song_reader
   import song_reader_pkg::*;
#(
   parameter int NOTE_W = NOTE_WIDTH,
   parameter int DUR_W  = DUR_WIDTH,
   parameter int ADDR_W = ADDR_WIDTH
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              play,
   input  logic [1:0]        song,
   input  logic              note_done,
   output logic [NOTE_W-1:0] note,
   output logic [DUR_W-1:0]  duration,
   output logic              new_note,
   output logic              co
);

   state_t              state_r;
   state_t              state_nxt_s;
   logic [ADDR_W-1:0]   index_r;
   logic [1:0]          song_q_r;
   logic [NOTE_W-1:0]   note_r;
   logic [DUR_W-1:0]    duration_r;
   logic                new_note_r;
   logic                co_r;

   logic [ROM_AW-1:0]   rom_addr_s;
   logic [ROM_DW-1:0]   rom_data_s;
   logic [NOTE_W-1:0]   rom_note_s;
   logic [DUR_W-1:0]    rom_dur_s;
   logic                song_chg_s;
   logic                last_s;
   logic                advance_s;
   logic                wrap_s;

   // The address is held from FETCH through LOAD, so the word read at the
   // FETCH->LOAD edge is the one LOAD hands to the output registers.
   assign rom_addr_s = {song_q_r, index_r};
   assign rom_note_s = rom_data_s[NOTE_W+DUR_W-1:DUR_W];
   assign rom_dur_s  = rom_data_s[DUR_W-1:0];
   assign song_chg_s = (song != song_q_r);
   assign last_s     = (index_r == {ADDR_W{1'b1}});

   song_rom u_rom (
      .clk  (clk),
      .addr (rom_addr_s),
      .data (rom_data_s)
   );

   // Next-state logic; a song change overrides every other transition
   always_comb begin
      state_nxt_s = state_r;
      advance_s   = 1'b0;
      wrap_s      = 1'b0;
      if (song_chg_s) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (play) begin
                  state_nxt_s = ST_FETCH;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_FETCH: begin
               state_nxt_s = ST_LOAD;
            end
            ST_LOAD: begin
               if (rom_dur_s != {DUR_W{1'b0}}) begin
                  state_nxt_s = ST_NEW;
               end else begin
                  state_nxt_s = ST_END;
               end
            end
            ST_NEW: begin
               state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
               // note_done is ignored while paused
               if (note_done && play) begin
                  if (last_s) begin
                     wrap_s      = 1'b1;
                     state_nxt_s = ST_END;
                  end else begin
                     advance_s   = 1'b1;
                     state_nxt_s = ST_FETCH;
                  end
               end else begin
                  state_nxt_s = ST_WAIT;
               end
            end
            ST_END: begin
               if (!play) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_END;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // State, index and song registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r  <= ST_IDLE;
         index_r  <= {ADDR_W{1'b0}};
         song_q_r <= song;
      end else begin
         state_r  <= state_nxt_s;
         song_q_r <= song;
         if (song_chg_s || wrap_s) begin
            index_r <= {ADDR_W{1'b0}};
         end else if (advance_s) begin
            index_r <= index_r + ADDR_W'(1);
         end else begin
            index_r <= index_r;
         end
      end
   end

   // Output registers: loaded on entry to NEW, cleared on entry to IDLE/END
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         note_r     <= {NOTE_W{1'b0}};
         duration_r <= {DUR_W{1'b0}};
         new_note_r <= 1'b0;
         co_r       <= 1'b0;
      end else begin
         new_note_r <= (state_nxt_s == ST_NEW);
         co_r       <= wrap_s;
         if (state_nxt_s == ST_NEW) begin
            note_r     <= rom_note_s;
            duration_r <= rom_dur_s;
         end else if ((state_nxt_s == ST_IDLE) || (state_nxt_s == ST_END)) begin
            note_r     <= {NOTE_W{1'b0}};
            duration_r <= {DUR_W{1'b0}};
         end else begin
            note_r     <= note_r;
            duration_r <= duration_r;
         end
      end
   end

   assign note     = note_r;
   assign duration = duration_r;
   assign new_note = new_note_r;
   assign co       = co_r;

endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader
// Directed bench for song_reader. Expected notes are pushed to a scoreboard
// queue whenever a fetch is triggered (play raised in IDLE or note_done in
// WAIT) and popped when the DUT pulses new_note.
module tb_song_reader;

   logic       clk;
   logic       reset_n;
   logic       play;
   logic [1:0] song;
   logic       note_done;
   logic [5:0] note;
   logic [5:0] duration;
   logic       new_note;
   logic       co;

   int checks;
   int errors;
   int nn_cnt;
   int co_cnt;
   logic [11:0] exp_q[$];

   song_reader dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .play      (play),
      .song      (song),
      .note_done (note_done),
      .note      (note),
      .duration  (duration),
      .new_note  (new_note),
      .co        (co)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference score, written from the song descriptions
   function automatic logic [11:0] model(input int s, input int i);
      int n;
      int d;
      case (s)
         0: begin n = 5 + i;  d = 12 + (i % 4); end
         1: begin n = 32 + i; d = i + 1; end
         2: begin n = 10 + i; d = (i == 3) ? 0 : i + 4; end
         3: begin n = 63 - i; d = 40 - i; end
         default: begin n = 0; d = 0; end
      endcase
      return {n[5:0], d[5:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock; note_done is always a single-cycle pulse
   task automatic tick();
      @(posedge clk);
      #1;
      note_done = 1'b0;
   endtask

   // Wait (bounded) for new_note; the first tick is the edge sampling the trigger
   task automatic expect_note(input string tag);
      int lat;
      logic [11:0] w;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (new_note !== 1'b1 && lat < 10);
      check({tag, " latency"}, lat, 3);
      check({tag, " pending"}, {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
         w = exp_q.pop_front();
         check({tag, " note"}, {26'd0, note}, {26'd0, w[11:6]});
         check({tag, " dur"}, {26'd0, duration}, {26'd0, w[5:0]});
      end
   endtask

   // Finish the current note two cycles after its new_note and expect the next
   task automatic next_note(input int s, input int i);
      tick();
      note_done = 1'b1;
      exp_q.push_back(model(s, i));
      expect_note($sformatf("s%0d i%0d", s, i));
   endtask

   // Pulse counters and the new_note/co exclusivity check
   always @(negedge clk) begin
      if (new_note === 1'b1) nn_cnt++;
      if (co === 1'b1) co_cnt++;
      if (new_note === 1'b1 || co === 1'b1) begin
         check("pulse overlap", {31'd0, new_note & co}, 32'd0);
      end
   end

   initial begin
      int nn_base;
      int co_base;
      checks = 0;
      errors = 0;
      nn_cnt = 0;
      co_cnt = 0;
      reset_n = 1'b0;
      play = 1'b0;
      song = 2'd0;
      note_done = 1'b0;
      tick();
      tick();
      check("rst note", {26'd0, note}, 32'd0);
      check("rst dur", {26'd0, duration}, 32'd0);
      check("rst new_note", {31'd0, new_note}, 32'd0);
      check("rst co", {31'd0, co}, 32'd0);
      reset_n = 1'b1;
      tick();

      // First note of song 0
      play = 1'b1;
      exp_q.push_back(model(0, 0));
      expect_note("start s0");
      tick();
      check("new_note one cycle", {31'd0, new_note}, 32'd0);

      // Full song 1 ending in exactly one co
      play = 1'b0;
      song = 2'd1;
      tick();
      check("song chg note", {26'd0, note}, 32'd0);
      check("song chg dur", {26'd0, duration}, 32'd0);
      nn_base = nn_cnt;
      co_base = co_cnt;
      play = 1'b1;
      exp_q.push_back(model(1, 0));
      expect_note("s1 i0");
      for (int i = 1; i < 32; i++) next_note(1, i);
      tick();
      note_done = 1'b1;
      tick();
      check("wrap co", {31'd0, co}, 32'd1);
      check("wrap dur", {26'd0, duration}, 32'd0);
      check("wrap note", {26'd0, note}, 32'd0);
      check("wrap new_note", {31'd0, new_note}, 32'd0);
      tick();
      check("co one cycle", {31'd0, co}, 32'd0);
      check("s1 new_note count", nn_cnt - nn_base, 32);
      check("s1 co count", co_cnt - co_base, 1);
      play = 1'b0;
      tick();
      play = 1'b1;
      exp_q.push_back(model(1, 0));
      expect_note("s1 restart");

      // Song 2 hits the end marker at entry 3
      play = 1'b0;
      song = 2'd2;
      tick();
      nn_base = nn_cnt;
      co_base = co_cnt;
      play = 1'b1;
      exp_q.push_back(model(2, 0));
      expect_note("s2 i0");
      next_note(2, 1);
      next_note(2, 2);
      tick();
      note_done = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      check("s2 end note", {26'd0, note}, 32'd0);
      check("s2 end dur", {26'd0, duration}, 32'd0);
      check("s2 new_note count", nn_cnt - nn_base, 3);
      check("s2 co count", co_cnt - co_base, 0);

      // Pause: note_done ignored while play is low
      play = 1'b0;
      tick();
      song = 2'd0;
      tick();
      play = 1'b1;
      exp_q.push_back(model(0, 0));
      expect_note("s0 pause i0");
      tick();
      nn_base = nn_cnt;
      play = 1'b0;
      note_done = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      check("pause note", {26'd0, note}, 32'd5);
      check("pause dur", {26'd0, duration}, 32'd12);
      check("pause new_note count", nn_cnt - nn_base, 0);
      play = 1'b1;
      next_note(0, 1);

      // Song change at index 31 in the same cycle as note_done
      play = 1'b0;
      song = 2'd1;
      tick();
      play = 1'b1;
      exp_q.push_back(model(1, 0));
      expect_note("s1b i0");
      for (int i = 1; i < 32; i++) next_note(1, i);
      tick();
      co_base = co_cnt;
      note_done = 1'b1;
      song = 2'd3;
      exp_q.push_back(model(3, 0));
      tick();
      check("chg31 co", {31'd0, co}, 32'd0);
      check("chg31 note", {26'd0, note}, 32'd0);
      check("chg31 dur", {26'd0, duration}, 32'd0);
      check("chg31 new_note", {31'd0, new_note}, 32'd0);
      expect_note("s3 i0");
      check("chg31 co count", co_cnt - co_base, 0);

      // Reset mid-song at index 17
      for (int i = 1; i < 18; i++) next_note(3, i);
      tick();
      co_base = co_cnt;
      reset_n = 1'b0;
      tick();
      check("midrst note", {26'd0, note}, 32'd0);
      check("midrst dur", {26'd0, duration}, 32'd0);
      check("midrst new_note", {31'd0, new_note}, 32'd0);
      check("midrst co", {31'd0, co}, 32'd0);
      reset_n = 1'b1;
      exp_q.push_back(model(3, 0));
      expect_note("s3 after rst");
      tick();
      check("midrst co count", co_cnt - co_base, 0);
      check("scoreboard drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
